// File: rtl/gray_step_pkg.sv
// rtl/gray_step_pkg.sv - shared types, step constants and Gray decode for gray_step_monitor
package gray_step_pkg;

  typedef enum logic [1:0] {
    INIT  = 2'd0,
    TRACK = 2'd1,
    FAULT = 2'd2
  } state_t;

  localparam logic [2:0] DELTA_UP = 3'd1;
  localparam logic [2:0] DELTA_DN = 3'd7;

  function automatic logic [2:0] gray2bin(input logic [2:0] g);
    return {g[2], g[2] ^ g[1], g[2] ^ g[1] ^ g[0]};
  endfunction

endpackage

// File: rtl/gray_step_monitor_if.sv
// rtl/gray_step_monitor_if.sv - Gray input / step-report bundle between the FSM consumer and its user
interface gray_step_monitor_if #(
  parameter int W = 8
);

  logic [2:0]   G;
  logic         clr;
  logic [2:0]   BIN;
  logic         STEP;
  logic         DIR;
  logic [W-1:0] POS;
  logic         ERR;

  modport master (
    output G, clr,
    input  BIN, STEP, DIR, POS, ERR
  );

  modport slave (
    input  G, clr,
    output BIN, STEP, DIR, POS, ERR
  );

endinterface

// File: rtl/gray_to_bin3.sv
// rtl/gray_to_bin3.sv - combinational 3-bit Gray to binary converter
module gray_to_bin3
  import gray_step_pkg::*;
(
  input  logic [2:0] gray,
  output logic [2:0] bin
);

  assign bin = gray2bin(gray);

endmodule

// File: rtl/gray_step_monitor.sv
// rtl/gray_step_monitor.sv - registers a 3-bit Gray code, classifies each change and tracks net position
module gray_step_monitor
  import gray_step_pkg::*;
#(
  parameter int W       = 8,
  parameter int SEQ_LEN = 8
) (
  input  logic                CLK,
  input  logic                reset,
  gray_step_monitor_if.slave  bus
);

  localparam logic [2:0] SEQ_MASK = 3'(SEQ_LEN - 1);

  state_t       state, state_nxt;
  logic [2:0]   g_q;
  logic [2:0]   bin_now;
  logic [2:0]   bin_q;
  logic [2:0]   bin_prev, bin_prev_nxt;
  logic [2:0]   delta;
  logic [W-1:0] pos_q, pos_nxt;
  logic         step_q, step_nxt;
  logic         dir_q, dir_nxt;
  logic         err_q, err_nxt;

  gray_to_bin3 u_g2b (
    .gray (g_q),
    .bin  (bin_now)
  );

  // Modulo-8 distance from the last accepted position; 1 and 7 are the only legal moves.
  assign delta = (bin_now - bin_prev) & SEQ_MASK;

  always_ff @(posedge CLK) begin
    if (!reset) begin
      state    <= INIT;
      g_q      <= 3'd0;
      bin_q    <= 3'd0;
      bin_prev <= 3'd0;
      pos_q    <= '0;
      step_q   <= 1'b0;
      dir_q    <= 1'b1;
      err_q    <= 1'b0;
    end else begin
      state    <= state_nxt;
      g_q      <= bus.G;
      bin_q    <= bin_now;
      bin_prev <= bin_prev_nxt;
      pos_q    <= pos_nxt;
      step_q   <= step_nxt;
      dir_q    <= dir_nxt;
      err_q    <= err_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    bin_prev_nxt = bin_prev;
    pos_nxt      = pos_q;
    dir_nxt      = dir_q;
    err_nxt      = err_q;
    step_nxt     = 1'b0;
    case (state)
      INIT: begin
        bin_prev_nxt = bin_now;
        state_nxt    = TRACK;
        if (bus.clr) pos_nxt = '0;
      end
      TRACK: begin
        if (delta == DELTA_UP || delta == DELTA_DN) begin
          // The reference point always advances so a coincident clr never loses a step.
          bin_prev_nxt = bin_now;
          dir_nxt      = (delta == DELTA_UP);
          if (bus.clr) begin
            pos_nxt = '0;
          end else begin
            step_nxt = 1'b1;
            pos_nxt  = (delta == DELTA_UP) ? pos_q + W'(1) : pos_q - W'(1);
          end
        end else if (delta != 3'd0) begin
          if (bus.clr) begin
            pos_nxt   = '0;
            state_nxt = INIT;
          end else begin
            err_nxt   = 1'b1;
            state_nxt = FAULT;
          end
        end else if (bus.clr) begin
          pos_nxt = '0;
        end
      end
      FAULT: begin
        if (bus.clr) begin
          err_nxt   = 1'b0;
          pos_nxt   = '0;
          state_nxt = INIT;
        end
      end
      default: state_nxt = INIT;
    endcase
  end

  assign bus.BIN  = bin_q;
  assign bus.STEP = step_q;
  assign bus.DIR  = dir_q;
  assign bus.POS  = pos_q;
  assign bus.ERR  = err_q;

endmodule

// File: tb/tb_gray_step_monitor.sv
// tb/tb_gray_step_monitor.sv - self-checking bench for gray_step_monitor
module tb_gray_step_monitor;

  localparam int W    = 8;
  localparam int MASK = (1 << W) - 1;

  logic CLK = 1'b0;
  logic reset;

  gray_step_monitor_if #(.W(W)) mon_if ();

  gray_step_monitor #(.W(W)) dut (
    .CLK   (CLK),
    .reset (reset),
    .bus   (mon_if)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic       r;
    logic [2:0] g;
    logic       c;
    int         bin;
    int         step;
    int         dir;
    int         pos;
    int         err;
  } vec_t;

  int n_vec  = 0;
  int n_miss = 0;
  int gseq[8] = '{0, 1, 3, 2, 6, 7, 5, 4};

  // Behavioural reference: position in the up-order list is the binary value.
  int m_gq, m_bin, m_prev, m_step, m_dir, m_pos, m_err;
  int m_synced, m_faulted, m_fresh;
  int cur;

  function automatic int seq_index(input int g);
    for (int i = 0; i < 8; i++) if (gseq[i] == g) return i;
    return 0;
  endfunction

  function void model_edge(input int g, input int c, input int r);
    int now, d;
    if (r == 0) begin
      m_gq = 0; m_bin = 0; m_prev = 0; m_step = 0; m_dir = 1; m_pos = 0; m_err = 0;
      m_fresh = 1; m_faulted = 0;
      return;
    end
    now    = seq_index(m_gq);
    d      = (now - m_prev + 8) % 8;
    m_step = 0;
    if (m_fresh != 0) begin
      m_prev  = now;
      m_fresh = 0;
      if (c != 0) m_pos = 0;
    end else if (m_faulted != 0) begin
      if (c != 0) begin
        m_err = 0; m_pos = 0; m_faulted = 0; m_fresh = 1;
      end
    end else if (d == 1 || d == 7) begin
      m_prev = now;
      m_dir  = (d == 1) ? 1 : 0;
      if (c != 0) m_pos = 0;
      else begin
        m_step = 1;
        m_pos  = (m_pos + ((d == 1) ? 1 : -1)) & MASK;
      end
    end else if (d != 0) begin
      if (c != 0) begin
        m_pos = 0; m_fresh = 1;
      end else begin
        m_err = 1; m_faulted = 1;
      end
    end else if (c != 0) begin
      m_pos = 0;
    end
    m_bin = now;
    m_gq  = g;
  endfunction

  task automatic check(input string name, input int bin, input int step, input int dir,
                       input int pos, input int err);
    n_vec++;
    if (mon_if.BIN !== 3'(bin) || mon_if.STEP !== 1'(step) || mon_if.DIR !== 1'(dir) ||
        mon_if.POS !== W'(pos) || mon_if.ERR !== 1'(err)) begin
      n_miss++;
      $display("FAIL %s: got bin=%0d step=%0d dir=%0d pos=%0d err=%0d, want bin=%0d step=%0d dir=%0d pos=%0d err=%0d",
               name, mon_if.BIN, mon_if.STEP, mon_if.DIR, mon_if.POS, mon_if.ERR,
               bin, step, dir, pos, err);
    end
  endtask

  task automatic check_val(input string name, input int got, input int want);
    n_vec++;
    if (got != want) begin
      n_miss++;
      $display("FAIL %s: got %0d, want %0d", name, got, want);
    end
  endtask

  task automatic tick(input logic [2:0] g, input logic c, input logic r, input string name);
    mon_if.G   = g;
    mon_if.clr = c;
    reset      = r;
    @(posedge CLK);
    model_edge(int'(g), int'(c), int'(r));
    #1;
    check(name, m_bin, m_step, m_dir, m_pos, m_err);
  endtask

  task automatic restart(input string name);
    tick(3'd0, 1'b0, 1'b0, name);
    tick(3'd0, 1'b0, 1'b1, name);
    tick(3'd0, 1'b0, 1'b1, name);
    cur = 0;
  endtask

  task automatic move(input int dstep, input logic c, input string name);
    cur = (cur + dstep + 8) % 8;
    tick(3'(gseq[cur]), 1'b0, 1'b1, name);
    tick(3'(gseq[cur]), c, 1'b1, name);
  endtask

  vec_t tbl[29];

  initial begin
    mon_if.G   = 3'd0;
    mon_if.clr = 1'b0;
    reset      = 1'b0;
    cur        = 0;

    // r, g, clr | bin, step, dir, pos, err after the edge
    tbl[0]  = '{1'b0, 3'd0, 1'b0, 0, 0, 1, 0, 0};
    tbl[1]  = '{1'b1, 3'd0, 1'b0, 0, 0, 1, 0, 0};
    tbl[2]  = '{1'b1, 3'd1, 1'b0, 0, 0, 1, 0, 0};
    tbl[3]  = '{1'b1, 3'd1, 1'b0, 1, 1, 1, 1, 0};
    tbl[4]  = '{1'b1, 3'd3, 1'b0, 1, 0, 1, 1, 0};
    tbl[5]  = '{1'b1, 3'd3, 1'b0, 2, 1, 1, 2, 0};
    tbl[6]  = '{1'b1, 3'd2, 1'b0, 2, 0, 1, 2, 0};
    tbl[7]  = '{1'b1, 3'd2, 1'b0, 3, 1, 1, 3, 0};
    tbl[8]  = '{1'b1, 3'd6, 1'b0, 3, 0, 1, 3, 0};
    tbl[9]  = '{1'b1, 3'd6, 1'b0, 4, 1, 1, 4, 0};
    tbl[10] = '{1'b1, 3'd7, 1'b0, 4, 0, 1, 4, 0};
    tbl[11] = '{1'b1, 3'd7, 1'b0, 5, 1, 1, 5, 0};
    tbl[12] = '{1'b1, 3'd5, 1'b0, 5, 0, 1, 5, 0};
    tbl[13] = '{1'b1, 3'd5, 1'b0, 6, 1, 1, 6, 0};
    tbl[14] = '{1'b1, 3'd4, 1'b0, 6, 0, 1, 6, 0};
    tbl[15] = '{1'b1, 3'd4, 1'b0, 7, 1, 1, 7, 0};
    tbl[16] = '{1'b1, 3'd0, 1'b0, 7, 0, 1, 7, 0};
    tbl[17] = '{1'b1, 3'd0, 1'b0, 0, 1, 1, 8, 0};
    tbl[18] = '{1'b1, 3'd4, 1'b0, 0, 0, 1, 8, 0};
    tbl[19] = '{1'b1, 3'd4, 1'b0, 7, 1, 0, 7, 0};
    tbl[20] = '{1'b1, 3'd5, 1'b0, 7, 0, 0, 7, 0};
    tbl[21] = '{1'b1, 3'd5, 1'b0, 6, 1, 0, 6, 0};
    tbl[22] = '{1'b1, 3'd2, 1'b0, 6, 0, 0, 6, 0};
    tbl[23] = '{1'b1, 3'd2, 1'b0, 3, 0, 0, 6, 1};
    tbl[24] = '{1'b1, 3'd6, 1'b0, 3, 0, 0, 6, 1};
    tbl[25] = '{1'b1, 3'd6, 1'b0, 4, 0, 0, 6, 1};
    tbl[26] = '{1'b1, 3'd6, 1'b1, 4, 0, 0, 0, 0};
    tbl[27] = '{1'b1, 3'd7, 1'b0, 4, 0, 0, 0, 0};
    tbl[28] = '{1'b1, 3'd7, 1'b0, 5, 1, 1, 1, 0};

    for (int i = 0; i < 29; i++) begin
      tick(tbl[i].g, tbl[i].c, tbl[i].r, $sformatf("model_tbl%0d", i));
      check($sformatf("table%0d", i), tbl[i].bin, tbl[i].step, tbl[i].dir, tbl[i].pos, tbl[i].err);
    end

    // Down walk from zero: 000 -> 100 -> 101
    restart("down_reset");
    move(-1, 1'b0, "down1");
    move(-1, 1'b0, "down2");
    check_val("down_pos", int'(mon_if.POS), 254);
    check_val("down_dir", int'(mon_if.DIR), 0);

    // Counter wrap at 2^W
    restart("wrap_reset");
    for (int i = 0; i < 255; i++) move(1, 1'b0, "wrap_walk");
    check_val("wrap_pos_ff", int'(mon_if.POS), 255);
    move(1, 1'b0, "wrap_last");
    check_val("wrap_pos_00", int'(mon_if.POS), 0);
    check_val("wrap_step", int'(mon_if.STEP), 1);

    // clr coinciding with a legal up step
    restart("clrstep_reset");
    move(1, 1'b0, "clrstep_a");
    move(1, 1'b0, "clrstep_b");
    move(1, 1'b1, "clrstep_clr");
    check_val("clrstep_pos", int'(mon_if.POS), 0);
    check_val("clrstep_step", int'(mon_if.STEP), 0);
    check_val("clrstep_dir", int'(mon_if.DIR), 1);
    move(1, 1'b0, "clrstep_next");
    check_val("clrstep_pos1", int'(mon_if.POS), 1);

    // Reset mid-operation with POS=5 and ERR=1
    restart("midrst_reset");
    for (int i = 0; i < 5; i++) move(1, 1'b0, "midrst_walk");
    move(3, 1'b0, "midrst_jump");
    check_val("midrst_err", int'(mon_if.ERR), 1);
    check_val("midrst_pos", int'(mon_if.POS), 5);
    tick(3'd0, 1'b0, 1'b0, "midrst_assert");
    check("midrst_values", 0, 0, 1, 0, 0);
    tick(3'd0, 1'b0, 1'b1, "midrst_rel1");
    check_val("midrst_nostep1", int'(mon_if.STEP), 0);
    tick(3'd0, 1'b0, 1'b1, "midrst_rel2");
    check_val("midrst_nostep2", int'(mon_if.STEP), 0);

    // Randomized traffic against the reference model
    restart("rand_reset");
    for (int i = 0; i < 3000; i++) begin
      int sel;
      logic c, r;
      sel = int'($urandom_range(0, 99));
      if (sel < 40) begin
      end else if (sel < 62) cur = (cur + 1) % 8;
      else if (sel < 84) cur = (cur + 7) % 8;
      else cur = int'($urandom_range(0, 7));
      c = ($urandom_range(0, 99) < 4);
      r = ($urandom_range(0, 299) != 0);
      tick(3'(gseq[cur]), c, r, "random");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
